// File: rtl/hw_reg_write_queue_pkg.sv
// Shared GPU host-path types: register write request and default widths.
// Used by the write queue and by the register file input side.
package hw_reg_write_queue_pkg;

  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned DATA_W_DEF = 8;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/hw_reg_write_queue_sync_fifo_ptr.sv
// Circular-buffer pointer unit: wrap-bit pointers, full/empty, level.
// Ports: clk, rst, clr, push, pop -> wr_idx, rd_idx, full, empty, level.
module sync_fifo_ptr
  import hw_reg_write_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  output logic [$clog2(DEPTH)-1:0]   wr_idx,
  output logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  // Same slot, different lap: writer is a full buffer ahead.
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
               && (wr_ptr[AW] != rd_ptr[AW]);
  assign level  = wr_ptr - rd_ptr;

endmodule

// File: rtl/hw_reg_write_queue.sv
// Buffered host write front-end for the GPU control register file.
// Ports: host_wr_req/addr/data/ready in, apply_en/flush gate, we/addr_out/data_out/fifo_level out.
module hw_reg_write_queue
  import hw_reg_write_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_wr_req,
  input  logic [ADDR_W-1:0]        host_addr,
  input  logic [DATA_W-1:0]        host_data,
  output logic                     host_wr_ready,
  input  logic                     apply_en,
  input  logic                     flush,
  output logic                     we,
  output logic [ADDR_W-1:0]        addr_out,
  output logic [DATA_W-1:0]        data_out,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = ADDR_W + DATA_W;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  assign host_wr_ready = !full && !flush;
  assign push          = host_wr_req && host_wr_ready;
  assign pop           = apply_en && !empty && !flush;

  sync_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .push   (push),
    .pop    (pop),
    .wr_idx (wr_idx),
    .rd_idx (rd_idx),
    .full   (full),
    .empty  (empty),
    .level  (fifo_level)
  );

  // Storage is deliberately not reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_idx] <= {host_addr, host_data};
  end

  assign head = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      we       <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
    end else begin
      we <= pop;
      if (pop) begin
        addr_out <= head[EW-1:DATA_W];
        data_out <= head[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_hw_reg_write_queue.sv
// Directed bench for hw_reg_write_queue with an in-order write scoreboard.
// Drives at posedge+1, samples outputs at posedge+1 and on negedge.
module tb_hw_reg_write_queue;
  import hw_reg_write_queue_pkg::*;

  logic        clk;
  logic        rst;
  logic        host_wr_req;
  logic [19:0] host_addr;
  logic [7:0]  host_data;
  logic        host_wr_ready;
  logic        apply_en;
  logic        flush;
  logic        we;
  logic [19:0] addr_out;
  logic [7:0]  data_out;
  logic [2:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;
  int n_we     = 0;
  int we_base;

  wr_req_t exp_q[$];

  hw_reg_write_queue #(
    .DEPTH  (4),
    .ADDR_W (20),
    .DATA_W (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .host_wr_req   (host_wr_req),
    .host_addr     (host_addr),
    .host_data     (host_data),
    .host_wr_ready (host_wr_ready),
    .apply_en      (apply_en),
    .flush         (flush),
    .we            (we),
    .addr_out      (addr_out),
    .data_out      (data_out),
    .fifo_level    (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [19:0] a,
                           input logic [7:0] d);
    wr_req_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Register-file write port scoreboard.
  always @(negedge clk) begin
    if (we) begin
      n_we++;
      if (exp_q.size() == 0) begin
        check("sb_extra_we", 32'(we), 32'd0);
      end else begin
        wr_req_t e;
        e = exp_q.pop_front();
        check("sb_addr", 32'(addr_out), 32'(e.addr));
        check("sb_data", 32'(data_out), 32'(e.data));
      end
    end
  end

  initial begin
    rst         = 1'b1;
    host_wr_req = 1'b0;
    host_addr   = '0;
    host_data   = '0;
    apply_en    = 1'b0;
    flush       = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // 1: reset state, then single write latency
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(addr_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(host_wr_ready), 32'd1);

    apply_en    = 1'b1;
    host_wr_req = 1'b1;
    host_addr   = 20'h00010;
    host_data   = 8'hA5;
    expect_wr(20'h00010, 8'hA5);
    tick();
    host_wr_req = 1'b0;
    check("t1_lvl1", 32'(fifo_level), 32'd1);
    check("t1_we_early", 32'(we), 32'd0);
    tick();
    check("t1_we", 32'(we), 32'd1);
    check("t1_addr", 32'(addr_out), 32'h00010);
    check("t1_data", 32'(data_out), 32'hA5);
    check("t1_lvl0", 32'(fifo_level), 32'd0);
    tick();
    check("t1_we_off", 32'(we), 32'd0);
    check("t1_hold", 32'(data_out), 32'hA5);

    // 2: fill while gated, stalled 5th write
    apply_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      host_wr_req = 1'b1;
      host_addr   = 20'h00100 + 20'(i);
      host_data   = 8'(i);
      expect_wr(20'h00100 + 20'(i), 8'(i));
      tick();
    end
    check("t2_lvl4", 32'(fifo_level), 32'd4);
    check("t2_full", 32'(host_wr_ready), 32'd0);
    host_addr = 20'h00105;
    host_data = 8'h05;
    expect_wr(20'h00105, 8'h05);
    tick();
    check("t2_stall_lvl", 32'(fifo_level), 32'd4);
    check("t2_stall_rdy", 32'(host_wr_ready), 32'd0);
    we_base  = n_we;
    apply_en = 1'b1;
    tick();
    check("t2_first_we", 32'(we), 32'd1);
    check("t2_rdy_back", 32'(host_wr_ready), 32'd1);
    tick();
    host_wr_req = 1'b0;
    check("t2_lvl_pp", 32'(fifo_level), 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_consec", 32'(we), 32'd1);
    end
    tick();
    check("t2_we_done", 32'(we), 32'd0);
    check("t2_pulses", 32'(n_we - we_base), 32'd5);
    check("t2_lvl_end", 32'(fifo_level), 32'd0);

    // 3: streaming across pointer wrap
    we_base = n_we;
    for (int i = 0; i < 10; i++) begin
      check("t3_ready", 32'(host_wr_ready), 32'd1);
      host_wr_req = 1'b1;
      host_addr   = 20'h00200 + 20'(i);
      host_data   = 8'h30 + 8'(i);
      expect_wr(20'h00200 + 20'(i), 8'h30 + 8'(i));
      tick();
      check("t3_lvl_le1", 32'(fifo_level <= 3'd1), 32'd1);
    end
    host_wr_req = 1'b0;
    repeat (4) tick();
    check("t3_pulses", 32'(n_we - we_base), 32'd10);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: flush drops queue and the flush-cycle push
    apply_en = 1'b0;
    we_base  = n_we;
    for (int i = 0; i < 3; i++) begin
      host_wr_req = 1'b1;
      host_addr   = 20'h00300 + 20'(i);
      host_data   = 8'h40 + 8'(i);
      tick();
    end
    check("t4_lvl3", 32'(fifo_level), 32'd3);
    host_addr = 20'h003EE;
    host_data = 8'hEE;
    flush     = 1'b1;
    #1;
    check("t4_rdy_flush", 32'(host_wr_ready), 32'd0);
    tick();
    flush       = 1'b0;
    host_wr_req = 1'b0;
    check("t4_lvl0", 32'(fifo_level), 32'd0);
    apply_en = 1'b1;
    repeat (3) tick();
    check("t4_no_we", 32'(n_we - we_base), 32'd0);
    check("t4_lvl_end", 32'(fifo_level), 32'd0);

    // 5: reset mid-drain
    apply_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      host_wr_req = 1'b1;
      host_addr   = 20'h00400 + 20'(i);
      host_data   = 8'h50 + 8'(i);
      expect_wr(20'h00400 + 20'(i), 8'h50 + 8'(i));
      tick();
    end
    host_wr_req = 1'b0;
    apply_en    = 1'b1;
    we_base     = n_we;
    tick();
    check("t5_first_we", 32'(we), 32'd1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    rst = 1'b0;
    check("t5_we", 32'(we), 32'd0);
    check("t5_addr", 32'(addr_out), 32'd0);
    check("t5_data", 32'(data_out), 32'd0);
    check("t5_lvl", 32'(fifo_level), 32'd0);
    check("t5_ready", 32'(host_wr_ready), 32'd1);
    repeat (3) tick();
    check("t5_pulses", 32'(n_we - we_base), 32'd1);

    // 6: simultaneous push/pop at level 2
    apply_en = 1'b0;
    we_base  = n_we;
    for (int i = 0; i < 2; i++) begin
      host_wr_req = 1'b1;
      host_addr   = 20'h00600 + 20'(i);
      host_data   = 8'h60 + 8'(i);
      expect_wr(20'h00600 + 20'(i), 8'h60 + 8'(i));
      tick();
    end
    check("t6_lvl2", 32'(fifo_level), 32'd2);
    apply_en = 1'b1;
    for (int i = 2; i < 6; i++) begin
      host_addr = 20'h00600 + 20'(i);
      host_data = 8'h60 + 8'(i);
      expect_wr(20'h00600 + 20'(i), 8'h60 + 8'(i));
      tick();
      check("t6_lvl_pp", 32'(fifo_level), 32'd2);
    end
    host_wr_req = 1'b0;
    repeat (4) tick();
    check("t6_pulses", 32'(n_we - we_base), 32'd6);
    check("t6_lvl_end", 32'(fifo_level), 32'd0);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
